// File: rtl/m_seq_code_gen_if.sv
// ---------------------------------------------------------------------------
// m_seq_code_gen_if
//   Control and code-output bundle of the m-sequence baseband source.
//   master : the controller / bench side (drives en, sync_clr, diff_en)
//   slave  : the generator side (drives the code bit and the two strobes)
// Signals
//   en              run enable; low freezes divider, LFSR and code output
//   sync_clr        synchronous restart, wins over en
//   diff_en         1 = differential (relative-phase) code, 0 = absolute
//   m_ser_code_out  registered serial code bit to the PSK modulator
//   bit_stb         one-cycle pulse in the first cycle of each new code bit
//   frame_stb       one-cycle pulse with bit_stb when the LFSR returns to SEED
// ---------------------------------------------------------------------------
interface m_seq_code_gen_if;
  logic en;
  logic sync_clr;
  logic diff_en;
  logic m_ser_code_out;
  logic bit_stb;
  logic frame_stb;

  modport master (
    output en,
    output sync_clr,
    output diff_en,
    input  m_ser_code_out,
    input  bit_stb,
    input  frame_stb
  );

  modport slave (
    input  en,
    input  sync_clr,
    input  diff_en,
    output m_ser_code_out,
    output bit_stb,
    output frame_stb
  );
endinterface

// File: rtl/m_seq_code_gen.sv
// ---------------------------------------------------------------------------
// m_seq_code_gen
//   Baseband source for the 2PSK modulator. A Fibonacci LFSR produces a
//   maximal-length PN sequence, one bit every CLK_DIV clocks, optionally
//   differentially encoded for 2DPSK.
// Parameters
//   CLK_DIV  clk cycles per code bit (>= 2)
//   LFSR_W   LFSR length; sequence period is 2^LFSR_W - 1
//   TAPS     feedback mask, bit i set -> state[i] enters the XOR
//   SEED     non-zero start state, loaded on reset and sync_clr
// Ports
//   clk    in  rising-edge system clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of m_seq_code_gen_if (en, sync_clr, diff_en in;
//          m_ser_code_out, bit_stb, frame_stb out)
// ---------------------------------------------------------------------------
module m_seq_code_gen #(
  parameter int unsigned        CLK_DIV = 1000,
  parameter int unsigned        LFSR_W  = 7,
  parameter logic [LFSR_W-1:0]  TAPS    = 7'b1100000,
  parameter logic [LFSR_W-1:0]  SEED    = 7'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  m_seq_code_gen_if.slave  bus
);

  localparam int unsigned     DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Feedback bit: parity of the tapped state bits.
  function automatic logic f_feedback(input logic [LFSR_W-1:0] state);
    return ^(state & TAPS);
  endfunction

  // Next LFSR state; the all-zero state would lock the register, so it is
  // steered back onto SEED instead of shifting.
  function automatic logic [LFSR_W-1:0] f_next_state(input logic [LFSR_W-1:0] state);
    if (state == '0) begin
      return SEED;
    end
    return {state[LFSR_W-2:0], f_feedback(state)};
  endfunction

  logic [DIV_W-1:0]  r_div_cnt;
  logic [LFSR_W-1:0] r_state;
  logic              r_code;
  logic              r_bit_stb;
  logic              r_frame_stb;

  logic              w_wrap;
  logic              w_lock;
  logic              w_raw_bit;
  logic [LFSR_W-1:0] w_next_state;
  logic              w_frame;

  always_comb begin
    w_wrap       = bus.en && (r_div_cnt == DIV_LAST);
    w_lock       = (r_state == '0);
    w_next_state = f_next_state(r_state);
    // The recovered-from-lockup bit is forced to 0 and never flags a frame,
    // even though the state lands on SEED.
    w_raw_bit    = w_lock ? 1'b0 : f_feedback(r_state);
    w_frame      = !w_lock && (w_next_state == SEED);
  end

  // ---- bit-update stage: divider, LFSR, encoder and strobes share one edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_state     <= SEED;
      r_code      <= 1'b0;
      r_bit_stb   <= 1'b0;
      r_frame_stb <= 1'b0;
    end else if (bus.sync_clr) begin
      r_div_cnt   <= '0;
      r_state     <= SEED;
      r_code      <= 1'b0;
      r_bit_stb   <= 1'b0;
      r_frame_stb <= 1'b0;
    end else begin
      // w_wrap already includes en, so strobes are 0 while frozen.
      r_bit_stb   <= w_wrap;
      r_frame_stb <= w_wrap && w_frame;
      if (bus.en) begin
        r_div_cnt <= w_wrap ? '0 : r_div_cnt + DIV_W'(1);
      end
      if (w_wrap) begin
        r_state <= w_next_state;
        // diff_en is only looked at here, so a change applies to the next bit.
        r_code  <= bus.diff_en ? (r_code ^ w_raw_bit) : w_raw_bit;
      end
    end
  end

  assign bus.m_ser_code_out = r_code;
  assign bus.bit_stb        = r_bit_stb;
  assign bus.frame_stb      = r_frame_stb;

endmodule

// File: tb/tb_m_seq_code_gen.sv
module tb_m_seq_code_gen;

  localparam int          CLK_DIV = 4;
  localparam logic [6:0]  SEED    = 7'h01;
  localparam logic [6:0]  TAPS    = 7'b1100000;

  typedef struct packed {
    logic        code;
    logic        frame;
    logic [15:0] gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  m_seq_code_gen_if bus ();

  m_seq_code_gen #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       q_exp[$];
  logic       cap[$];
  logic       t1_bits[$];
  exp_t       mon_e;
  int         n_cmp   = 0;
  int         n_err   = 0;
  int         n_frame = 0;
  longint     cyc      = 0;
  longint     last_stb = 0;
  logic [6:0] ref_state;
  logic       ref_code;
  int         t1_head[7] = '{0, 0, 0, 0, 0, 1, 1};
  int         t2_head[7] = '{0, 0, 0, 0, 0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every bit strobe pops one expected bit from the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.bit_stb === 1'b1) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_bit_stb", 32'd1, 32'd0);
        end else begin
          mon_e = q_exp.pop_front();
          chk("code", 32'(bus.m_ser_code_out), 32'(mon_e.code));
          chk("frame_stb", 32'(bus.frame_stb), 32'(mon_e.frame));
          chk("bit_gap", 32'(cyc - last_stb), 32'(mon_e.gap));
        end
        cap.push_back(bus.m_ser_code_out);
        if (bus.frame_stb === 1'b1) n_frame++;
        last_stb = cyc;
      end else if (bus.frame_stb !== 1'b0) begin
        chk("frame_without_bit_stb", 32'(bus.frame_stb), 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ref_clear();
    ref_state = SEED;
    ref_code  = 1'b0;
  endtask

  // Reference: x^7 + x^6 + 1 Fibonacci LFSR with lock-up recovery.
  task automatic push_bit(input logic diff, input int gap);
    logic       fb;
    logic       r;
    logic       frm;
    logic [6:0] nxt;
    fb = 1'b0;
    for (int i = 0; i < 7; i++) if (TAPS[i]) fb ^= ref_state[i];
    if (ref_state == 7'd0) begin
      nxt = SEED;
      r   = 1'b0;
      frm = 1'b0;
    end else begin
      nxt = {ref_state[5:0], fb};
      r   = fb;
      frm = (nxt == SEED);
    end
    ref_code  = diff ? (ref_code ^ r) : r;
    ref_state = nxt;
    q_exp.push_back('{code: ref_code, frame: frm, gap: 16'(gap)});
  endtask

  task automatic pulse_sync_clr();
    bus.sync_clr = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    step(2);
    chk(tag, 32'(q_exp.size()), 32'd0);
    q_exp.delete();
  endtask

  task automatic check_head(input string tag, input int offs);
    for (int i = 0; i < 7; i++)
      chk($sformatf("%s_bit%0d", tag, i + 1), 32'(cap[offs + i]), 32'(t1_head[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ones;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.sync_clr = 1'b0;
    bus.diff_en  = 1'b0;
    step(3);
    chk("rst_code", 32'(bus.m_ser_code_out), 32'd0);
    chk("rst_bit_stb", 32'(bus.bit_stb), 32'd0);
    chk("rst_frame_stb", 32'(bus.frame_stb), 32'd0);
    rst_n = 1'b1;
    step(1);

    // T1: absolute sequence, one full period plus 7 bits
    ref_clear();
    cap.delete();
    n_frame = 0;
    for (int i = 0; i < 134; i++) push_bit(1'b0, CLK_DIV);
    last_stb = cyc;
    bus.en   = 1'b1;
    step(134 * CLK_DIV);
    bus.en   = 1'b0;
    drain_check("t1_drain");
    chk("t1_count", 32'(cap.size()), 32'd134);
    check_head("t1", 0);
    ones = 0;
    for (int i = 0; i < 127; i++) if (cap[i] === 1'b1) ones++;
    chk("t1_ones", 32'(ones), 32'd64);
    chk("t1_frames", 32'(n_frame), 32'd1);
    for (int i = 0; i < 7; i++) chk("t1_repeat", 32'(cap[127 + i]), 32'(cap[i]));
    t1_bits = cap;

    // T2: differential encoding
    pulse_sync_clr();
    bus.diff_en = 1'b1;
    ref_clear();
    cap.delete();
    for (int i = 0; i < 14; i++) push_bit(1'b1, CLK_DIV);
    last_stb = cyc;
    bus.en   = 1'b1;
    step(14 * CLK_DIV);
    bus.en   = 1'b0;
    drain_check("t2_drain");
    for (int i = 0; i < 7; i++) chk($sformatf("t2_bit%0d", i + 1), 32'(cap[i]), 32'(t2_head[i]));
    for (int i = 0; i < 14; i++)
      chk("t2_xor", 32'(cap[i] ^ ((i == 0) ? 1'b0 : cap[i - 1])), 32'(t1_bits[i]));

    // T3: en dropped for 10 clk at div_cnt=2 stretches that bit to 14 clk
    pulse_sync_clr();
    bus.diff_en = 1'b0;
    ref_clear();
    cap.delete();
    push_bit(1'b0, CLK_DIV);
    push_bit(1'b0, CLK_DIV + 10);
    for (int i = 0; i < 5; i++) push_bit(1'b0, CLK_DIV);
    last_stb = cyc;
    bus.en   = 1'b1;
    step(CLK_DIV + 2);
    bus.en   = 1'b0;
    step(10);
    bus.en   = 1'b1;
    step(2 + 5 * CLK_DIV);
    bus.en   = 1'b0;
    drain_check("t3_drain");
    chk("t3_count", 32'(cap.size()), 32'd7);
    check_head("t3", 0);

    // T4: sync_clr on the edge that would otherwise update the bit
    chk("t4_pre_code", 32'(bus.m_ser_code_out), 32'd1);
    bus.en = 1'b1;
    step(CLK_DIV - 1);
    bus.sync_clr = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
    chk("t4_code_cleared", 32'(bus.m_ser_code_out), 32'd0);
    chk("t4_no_bit_stb", 32'(bus.bit_stb), 32'd0);
    ref_clear();
    cap.delete();
    for (int i = 0; i < 7; i++) push_bit(1'b0, CLK_DIV);
    last_stb = cyc;
    step(7 * CLK_DIV);
    bus.en = 1'b0;
    drain_check("t4_drain");
    check_head("t4", 0);

    // T5: asynchronous reset between edges, mid-frame
    pulse_sync_clr();
    ref_clear();
    cap.delete();
    for (int i = 0; i < 7; i++) push_bit(1'b0, CLK_DIV);
    last_stb = cyc;
    bus.en   = 1'b1;
    step(7 * CLK_DIV + 2);
    chk("t5_pre_code", 32'(bus.m_ser_code_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_code", 32'(bus.m_ser_code_out), 32'd0);
    chk("t5_async_bit_stb", 32'(bus.bit_stb), 32'd0);
    bus.en = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("t5_drain", 32'(q_exp.size()), 32'd0);
    ref_clear();
    cap.delete();
    for (int i = 0; i < 7; i++) push_bit(1'b0, CLK_DIV);
    last_stb = cyc;
    bus.en   = 1'b1;
    step(7 * CLK_DIV);
    bus.en   = 1'b0;
    drain_check("t5_drain_after");
    check_head("t5", 0);

    // T6: LFSR forced to all-zero recovers onto SEED with a 0 bit
    force dut.r_state = 7'd0;
    step(1);
    release dut.r_state;
    ref_state = 7'd0;
    cap.delete();
    for (int i = 0; i < 8; i++) push_bit(1'b0, CLK_DIV);
    last_stb = cyc;
    bus.en   = 1'b1;
    step(CLK_DIV);
    chk("t6_state_seed", 32'(dut.r_state), 32'(SEED));
    step(7 * CLK_DIV);
    bus.en = 1'b0;
    drain_check("t6_drain");
    chk("t6_lockup_bit", 32'(cap[0]), 32'd0);
    check_head("t6", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
